// File: rtl/game_board_ctrl.sv
// Tic-tac-toe board controller: cursor movement, mark placement, win/draw
// detection and per-player round scores, all outputs registered.
module game_board_ctrl #(
    parameter int SCORE_MAX = 9
) (
    input  logic        clk,
    input  logic        resetButton,
    input  logic        up_pulse,
    input  logic        down_pulse,
    input  logic        left_pulse,
    input  logic        right_pulse,
    input  logic        place_pulse,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [1:0]  winner,
    output logic [3:0]  x_score,
    output logic [3:0]  o_score,
    output logic [3:0]  move_count
);

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        WIN   = 2'b10,
        DRAW  = 2'b11
    } gameStateT;

    localparam logic [3:0] SCORE_CAP = 4'(SCORE_MAX);

    gameStateT   state, stateNext;
    logic [17:0] boardNext;
    logic [3:0]  cursorNext, xScoreNext, oScoreNext, moveCountNext;
    logic [1:0]  winnerNext, lineMark, cursorCol;
    logic        turnNext, startPlayer, startPlayerNext, cellEmpty;

    // Returns the mark owning a complete row, column or diagonal, or 00.
    function automatic logic [1:0] lineWinner(input logic [17:0] b);
        logic [1:0] c [9];
        logic [1:0] found;
        for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
        found = 2'b00;
        for (int k = 0; k < 3; k++) begin
            if (c[3*k] != 2'b00 && c[3*k] == c[3*k+1] && c[3*k] == c[3*k+2]) found = c[3*k];
            if (c[k] != 2'b00 && c[k] == c[k+3] && c[k] == c[k+6]) found = c[k];
        end
        if (c[4] != 2'b00 && c[0] == c[4] && c[4] == c[8]) found = c[4];
        if (c[4] != 2'b00 && c[2] == c[4] && c[4] == c[6]) found = c[4];
        return found;
    endfunction

    assign lineMark   = lineWinner(board);
    assign game_state = state;

    always_comb begin
        cursorCol = 2'd2;
        case (cursor)
            4'd0, 4'd3, 4'd6: cursorCol = 2'd0;
            4'd1, 4'd4, 4'd7: cursorCol = 2'd1;
            default:          cursorCol = 2'd2;
        endcase
    end

    always_comb begin
        cellEmpty = 1'b0;
        for (int i = 0; i < 9; i++)
            if (cursor == 4'(i)) cellEmpty = (board[2*i +: 2] == 2'b00);
    end

    always_comb begin
        // NOTE: every next-value gets its hold default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        stateNext       = state;
        boardNext       = board;
        cursorNext      = cursor;
        turnNext        = turn;
        winnerNext      = winner;
        xScoreNext      = x_score;
        oScoreNext      = o_score;
        moveCountNext   = move_count;
        startPlayerNext = startPlayer;

        case (state)
            PLAY: begin
                if (place_pulse) begin
                    if (cellEmpty) begin
                        for (int i = 0; i < 9; i++)
                            if (cursor == 4'(i)) boardNext[2*i +: 2] = turn ? 2'b10 : 2'b01;
                        moveCountNext = move_count + 4'd1;
                        turnNext      = ~turn;
                        stateNext     = CHECK;
                    end
                end else if (up_pulse) begin
                    cursorNext = (cursor >= 4'd3) ? cursor - 4'd3 : cursor + 4'd6;
                end else if (down_pulse) begin
                    cursorNext = (cursor <= 4'd5) ? cursor + 4'd3 : cursor - 4'd6;
                end else if (left_pulse) begin
                    cursorNext = (cursorCol == 2'd0) ? cursor + 4'd2 : cursor - 4'd1;
                end else if (right_pulse) begin
                    cursorNext = (cursorCol == 2'd2) ? cursor - 4'd2 : cursor + 4'd1;
                end
            end
            CHECK: begin
                // A completed line wins even when it is the ninth mark.
                if (lineMark != 2'b00) begin
                    stateNext  = WIN;
                    winnerNext = lineMark;
                    if (lineMark == 2'b01 && x_score < SCORE_CAP) xScoreNext = x_score + 4'd1;
                    if (lineMark == 2'b10 && o_score < SCORE_CAP) oScoreNext = o_score + 4'd1;
                end else if (move_count == 4'd9) begin
                    stateNext  = DRAW;
                    winnerNext = 2'b11;
                end else begin
                    stateNext = PLAY;
                end
            end
            default: begin
                if (place_pulse) begin
                    stateNext       = PLAY;
                    boardNext       = '0;
                    moveCountNext   = 4'd0;
                    winnerNext      = 2'b00;
                    cursorNext      = 4'd4;
                    startPlayerNext = ~startPlayer;
                    turnNext        = ~startPlayer;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (resetButton) begin
            // NOTE: the board is an 18-bit flop vector rather than a RAM, so it
            // is cleared directly in reset along with the rest of the state.
            state       <= PLAY;
            board       <= '0;
            cursor      <= 4'd4;
            turn        <= 1'b0;
            winner      <= 2'b00;
            x_score     <= 4'd0;
            o_score     <= 4'd0;
            move_count  <= 4'd0;
            startPlayer <= 1'b0;
        end else begin
            state       <= stateNext;
            board       <= boardNext;
            cursor      <= cursorNext;
            turn        <= turnNext;
            winner      <= winnerNext;
            x_score     <= xScoreNext;
            o_score     <= oScoreNext;
            move_count  <= moveCountNext;
            startPlayer <= startPlayerNext;
        end
    end

endmodule

// File: tb/tb_game_board_ctrl.sv
// Bench for game_board_ctrl: a cell-array game model checked every cycle,
// plus literal expectations for the scripted scenarios.
module tb_game_board_ctrl;

    localparam int SCORE_MAX = 3;
    localparam int PH_PLAY = 0, PH_CHECK = 1, PH_WIN = 2, PH_DRAW = 3;

    logic        clk = 1'b0;
    logic        resetButton = 1'b1;
    logic        up_pulse = 1'b0, down_pulse = 1'b0, left_pulse = 1'b0, right_pulse = 1'b0;
    logic        place_pulse = 1'b0;
    logic [17:0] board;
    logic [3:0]  cursor, x_score, o_score, move_count;
    logic        turn;
    logic [1:0]  game_state, winner;

    always #5 clk = ~clk;

    game_board_ctrl #(.SCORE_MAX(SCORE_MAX)) dut (
        .clk(clk), .resetButton(resetButton),
        .up_pulse(up_pulse), .down_pulse(down_pulse),
        .left_pulse(left_pulse), .right_pulse(right_pulse),
        .place_pulse(place_pulse),
        .board(board), .cursor(cursor), .turn(turn),
        .game_state(game_state), .winner(winner),
        .x_score(x_score), .o_score(o_score), .move_count(move_count)
    );

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    // Game model: cells hold 0 empty, 1 X, 2 O; cursor kept as row/col.
    int mCell [9];
    int mRow, mCol, mTurn, mPhase, mWinner, mX, mO, mMoves, mStarter;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    int winXa   [5] = '{4, 0, 1, 2, 7};
    int rowOne  [6] = '{0, 3, 1, 4, 8, 5};
    int drawSeq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int lateWin [9] = '{2, 1, 7, 4, 0, 5, 3, 8, 6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lineOwner();
        for (int l = 0; l < 8; l++) begin
            int a = mCell[lines[l][0]];
            if (a != 0 && a == mCell[lines[l][1]] && a == mCell[lines[l][2]]) return a;
        end
        return 0;
    endfunction

    function automatic void clearBoard();
        for (int i = 0; i < 9; i++) mCell[i] = 0;
        mRow = 1; mCol = 1; mMoves = 0; mWinner = 0; mPhase = PH_PLAY;
    endfunction

    function automatic void modelReset();
        clearBoard();
        mTurn = 0; mX = 0; mO = 0; mStarter = 0;
    endfunction

    function automatic void modelEdge(input bit rst, pl, u, d, l, r);
        int w;
        if (rst) begin
            modelReset();
            return;
        end
        case (mPhase)
            PH_PLAY: begin
                if (pl) begin
                    if (mCell[3*mRow + mCol] == 0) begin
                        mCell[3*mRow + mCol] = mTurn + 1;
                        mMoves++;
                        mTurn = 1 - mTurn;
                        mPhase = PH_CHECK;
                    end
                end
                else if (u) mRow = (mRow + 2) % 3;
                else if (d) mRow = (mRow + 1) % 3;
                else if (l) mCol = (mCol + 2) % 3;
                else if (r) mCol = (mCol + 1) % 3;
            end
            PH_CHECK: begin
                w = lineOwner();
                if (w != 0) begin
                    mPhase = PH_WIN;
                    mWinner = w;
                    if (w == 1 && mX < SCORE_MAX) mX++;
                    if (w == 2 && mO < SCORE_MAX) mO++;
                end else if (mMoves == 9) begin
                    mPhase = PH_DRAW;
                    mWinner = 3;
                end else begin
                    mPhase = PH_PLAY;
                end
            end
            default: begin
                if (pl) begin
                    clearBoard();
                    mStarter = 1 - mStarter;
                    mTurn = mStarter;
                end
            end
        endcase
    endfunction

    function automatic logic [17:0] modelBoard();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mCell[i]);
        return b;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            check("board", 32'(board), 32'(modelBoard()));
            check("cursor", 32'(cursor), 32'(3*mRow + mCol));
            check("turn", 32'(turn), 32'(mTurn));
            check("game_state", 32'(game_state), 32'(mPhase));
            check("winner", 32'(winner), 32'(mWinner));
            check("x_score", 32'(x_score), 32'(mX));
            check("o_score", 32'(o_score), 32'(mO));
            check("move_count", 32'(move_count), 32'(mMoves));
        end
    end

    task automatic step(input bit rst, pl, u, d, l, r);
        resetButton = rst; place_pulse = pl;
        up_pulse = u; down_pulse = d; left_pulse = l; right_pulse = r;
        @(posedge clk);
        modelEdge(rst, pl, u, d, l, r);
        #1;
        resetButton = 1'b0; place_pulse = 1'b0;
        up_pulse = 1'b0; down_pulse = 1'b0; left_pulse = 1'b0; right_pulse = 1'b0;
    endtask

    task automatic resetDut();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);
    endtask

    task automatic gotoCell(input int c);
        for (int k = 0; k < 3 && mRow != c / 3; k++) step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3 && mCol != c % 3; k++) step(0, 0, 0, 0, 0, 1);
    endtask

    // Place on an empty cell, then poke place+up during the CHECK cycle.
    task automatic placeAt(input int c);
        gotoCell(c);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_board"}, 32'(board), 32'h0);
        check({tag, "_cursor"}, 32'(cursor), 32'd4);
        check({tag, "_turn"}, 32'(turn), 32'd0);
        check({tag, "_state"}, 32'(game_state), 32'd0);
        check({tag, "_winner"}, 32'(winner), 32'd0);
        check({tag, "_xs"}, 32'(x_score), 32'd0);
        check({tag, "_os"}, 32'(o_score), 32'd0);
        check({tag, "_moves"}, 32'(move_count), 32'd0);
    endtask

    initial begin
        modelReset();
        resetDut();
        checkEn = 1'b1;
        checkResetValues("rst");

        // Column-1 win for X in five moves, then board hold and new round.
        foreach (winXa[i]) placeAt(winXa[i]);
        check("win_state", 32'(game_state), 32'd2);
        check("win_winner", 32'(winner), 32'd1);
        check("win_xs", 32'(x_score), 32'd1);
        check("win_moves", 32'(move_count), 32'd5);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("win_hold_board", 32'(board), 32'h04126);
        step(0, 1, 0, 0, 0, 0);
        check("new_turn", 32'(turn), 32'd1);
        check("new_cursor", 32'(cursor), 32'd4);
        check("new_xs", 32'(x_score), 32'd1);
        foreach (rowOne[i]) placeAt(rowOne[i]);
        check("ostart_xs", 32'(x_score), 32'd2);

        // Cursor priority and wrap-around.
        resetDut();
        step(0, 0, 1, 0, 1, 0);
        check("cur_up_left", 32'(cursor), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        check("cur_up_wrap", 32'(cursor), 32'd7);
        step(0, 0, 0, 0, 1, 0);
        check("cur_left1", 32'(cursor), 32'd6);
        step(0, 0, 0, 0, 1, 0);
        check("cur_left_wrap", 32'(cursor), 32'd8);
        step(0, 0, 0, 0, 0, 1);
        check("cur_right_wrap", 32'(cursor), 32'd6);
        step(0, 0, 0, 1, 0, 0);
        check("cur_down_wrap", 32'(cursor), 32'd0);
        step(0, 0, 0, 1, 0, 1);
        check("cur_down_right", 32'(cursor), 32'd3);

        // Placing twice on the same cell.
        resetDut();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("occ_board", 32'(board), 32'h00100);
        check("occ_turn", 32'(turn), 32'd1);
        check("occ_moves", 32'(move_count), 32'd1);
        check("occ_state", 32'(game_state), 32'd0);

        // Full board with no line.
        resetDut();
        foreach (drawSeq[i]) placeAt(drawSeq[i]);
        check("draw_state", 32'(game_state), 32'd3);
        check("draw_winner", 32'(winner), 32'd3);
        check("draw_xs", 32'(x_score), 32'd0);
        check("draw_os", 32'(o_score), 32'd0);
        step(0, 1, 0, 0, 0, 0);
        check("draw_new_state", 32'(game_state), 32'd0);
        check("draw_new_board", 32'(board), 32'h0);
        check("draw_new_turn", 32'(turn), 32'd1);

        // O wins row 1 with X starting.
        resetDut();
        foreach (rowOne[i]) placeAt(rowOne[i]);
        check("owin_winner", 32'(winner), 32'd2);
        check("owin_os", 32'(o_score), 32'd1);

        // Win completed by the ninth mark.
        resetDut();
        foreach (lateWin[i]) placeAt(lateWin[i]);
        check("late_state", 32'(game_state), 32'd2);
        check("late_winner", 32'(winner), 32'd1);
        check("late_moves", 32'(move_count), 32'd9);

        // Score saturation, then reset while in CHECK.
        resetDut();
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) foreach (winXa[i]) placeAt(winXa[i]);
            else            foreach (rowOne[i]) placeAt(rowOne[i]);
            if (r == 2) check("sat_reach", 32'(x_score), 32'd3);
            if (r == 3) check("sat_hold", 32'(x_score), 32'd3);
            step(0, 1, 0, 0, 0, 0);
        end
        step(0, 1, 0, 0, 0, 0);
        check("pre_rst_state", 32'(game_state), 32'd1);
        step(1, 1, 1, 0, 0, 0);
        checkResetValues("chk_rst");
        step(0, 0, 0, 0, 0, 0);
        checkResetValues("post_rst");

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
